// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus layout, WARL masks, cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam logic [63:0] MSTATUS_WMASK  = 64'h0000_0000_0000_0088;

  localparam logic [63:0] MTVEC_WMASK = ~64'h2;
  localparam logic [63:0] MEPC_WMASK  = ~64'h1;
  localparam logic [63:0] MISA_RV64I  = 64'h8000_0000_0000_0100;

  localparam logic [63:0] CAUSE_MISALIGNED_FETCH = 64'd0;
  localparam logic [63:0] CAUSE_ILLEGAL_INSN     = 64'd2;
  localparam logic [63:0] CAUSE_BREAKPOINT       = 64'd3;
  localparam logic [63:0] CAUSE_MISALIGNED_LOAD  = 64'd4;
  localparam logic [63:0] CAUSE_MISALIGNED_STORE = 64'd6;
  localparam logic [63:0] CAUSE_ECALL_M          = 64'd11;

  // MPP is hardwired to machine mode since no other privilege level exists.
  function automatic logic [63:0] mstatus_rd(input logic mie, input logic mpie);
    logic [63:0] v;
    v = '0;
    v[MSTATUS_MPP_LO +: 2] = 2'b11;
    v[MSTATUS_MIE]         = mie;
    v[MSTATUS_MPIE]        = mpie;
    return v & (MSTATUS_WMASK | 64'h1800);
  endfunction

endpackage

// File: rtl/csr_if.sv
// Read/write port between the CSR functional unit and the CSR register file.
interface csr_if #(parameter int unsigned XLEN = 64);
  logic [11:0]     raddr;
  logic [XLEN-1:0] rdata;
  logic [11:0]     waddr;
  logic [XLEN-1:0] wdata;
  logic            wvalid;

  modport slave  (input raddr, output rdata, input waddr, input wdata, input wvalid);
  modport master (output raddr, input rdata, output waddr, output wdata, output wvalid);
endinterface

// File: rtl/csr_counter.sv
// Free-running counter with a load port; a load in the same cycle as an increment wins.
module csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      cnt <= '0;
    else if (wr_en) cnt <= wr_data;
    else if (inc)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational reads, commit-time writes, counters,
// and trap-entry / mret updates of mstatus, mepc, mcause, mtval.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] HART_ID  = '0,
  parameter logic [XLEN-1:0] MISA_VAL = XLEN'(MISA_RV64I)
) (
  input  logic            clk,
  input  logic            rstn,
  csr_if.slave            csr_io,
  input  logic            retire_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o,
  output logic            illegal_o
);

  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mie_reg, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic [XLEN-1:0] rdata_c;

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (1'b1),
    .wr_en   (csr_io.wvalid && csr_io.waddr == CSR_MCYCLE),
    .wr_data (csr_io.wdata),
    .cnt     (mcycle_q)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (retire_i),
    .wr_en   (csr_io.wvalid && csr_io.waddr == CSR_MINSTRET),
    .wr_data (csr_io.wdata),
    .cnt     (minstret_q)
  );

  // Trap/mret updates come after the CSR write so their later non-blocking
  // assignments override a same-cycle FU write to the same register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_reg    <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (csr_io.wvalid) begin
        case (csr_io.waddr)
          CSR_MSTATUS: begin
            mie_q  <= csr_io.wdata[MSTATUS_MIE];
            mpie_q <= csr_io.wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_reg    <= csr_io.wdata;
          CSR_MTVEC:    mtvec_q    <= csr_io.wdata & XLEN'(MTVEC_WMASK);
          CSR_MSCRATCH: mscratch_q <= csr_io.wdata;
          CSR_MEPC:     mepc_q     <= csr_io.wdata & XLEN'(MEPC_WMASK);
          CSR_MCAUSE:   mcause_q   <= csr_io.wdata;
          CSR_MTVAL:    mtval_q    <= csr_io.wdata;
          default: ;
        endcase
      end
      if (trap_valid_i) begin
        mepc_q   <= trap_pc_i & XLEN'(MEPC_WMASK);
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata_c   = '0;
    illegal_o = 1'b0;
    unique case (csr_io.raddr)
      CSR_MSTATUS:   rdata_c = XLEN'(mstatus_rd(mie_q, mpie_q));
      CSR_MISA:      rdata_c = MISA_VAL;
      CSR_MIE:       rdata_c = mie_reg;
      CSR_MTVEC:     rdata_c = mtvec_q;
      CSR_MSCRATCH:  rdata_c = mscratch_q;
      CSR_MEPC:      rdata_c = mepc_q;
      CSR_MCAUSE:    rdata_c = mcause_q;
      CSR_MTVAL:     rdata_c = mtval_q;
      CSR_MIP:       rdata_c = '0;
      CSR_MCYCLE:    rdata_c = mcycle_q;
      CSR_MINSTRET:  rdata_c = minstret_q;
      CSR_MHARTID:   rdata_c = HART_ID;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata_c = '0;
      default:       illegal_o = 1'b1;
    endcase
  end

  assign csr_io.rdata = rdata_c;
  assign mtvec_o      = mtvec_q;
  assign mepc_o       = mepc_q;
  assign mie_o        = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: vector table for write/readback plus hand sequences.
module tb_csr_regfile;
  import csr_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] HART = 64'd3;
  localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            retire_i, trap_valid_i, mret_i;
  logic [XLEN-1:0] trap_cause_i, trap_pc_i, trap_tval_i;
  logic [XLEN-1:0] mtvec_o, mepc_o;
  logic            mie_o, illegal_o;

  csr_if #(.XLEN(XLEN)) bus ();

  csr_regfile #(.XLEN(XLEN), .HART_ID(HART), .MISA_VAL(MISA)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .csr_io       (bus),
    .retire_i     (retire_i),
    .trap_valid_i (trap_valid_i),
    .trap_cause_i (trap_cause_i),
    .trap_pc_i    (trap_pc_i),
    .trap_tval_i  (trap_tval_i),
    .mret_i       (mret_i),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_o        (mie_o),
    .illegal_o    (illegal_o)
  );

  always #25 clk = ~clk;

  typedef struct {
    string       nm;
    logic [63:0] d;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [11:0] a;
    logic [63:0] wd;
    logic [63:0] exp;
    logic        ill;
    string       nm;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected read result is queued when the address is driven and retired
  // against the DUT once the combinational read has settled.
  task automatic rd(input logic [11:0] a, input logic [63:0] d, input logic ill, input string nm);
    exp_t e;
    bus.raddr = a;
    sb.push_back('{nm: nm, d: d, ill: ill});
    #1;
    e = sb.pop_front();
    n_checks++;
    if (bus.rdata !== e.d || illegal_o !== e.ill) begin
      n_errors++;
      $display("FAIL %s: got rdata=%h illegal=%b expected rdata=%h illegal=%b",
               e.nm, bus.rdata, illegal_o, e.d, e.ill);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.wvalid = 1'b1;
    bus.waddr  = a;
    bus.wdata  = d;
    step();
    bus.wvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{12'h340, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, "mscratch"};
    vecs[1]  = '{12'h305, 64'h8000_0003, 64'h8000_0001, 1'b0, "mtvec_warl"};
    vecs[2]  = '{12'h341, 64'h1235, 64'h1234, 1'b0, "mepc_warl"};
    vecs[3]  = '{12'h300, '1, 64'h1888, 1'b0, "mstatus_ones"};
    vecs[4]  = '{12'h300, 64'h0, 64'h1800, 1'b0, "mstatus_zero"};
    vecs[5]  = '{12'h344, '1, 64'h0, 1'b0, "mip_ro"};
    vecs[6]  = '{12'h301, 64'h0, MISA, 1'b0, "misa_ro"};
    vecs[7]  = '{12'hF14, 64'hFF, HART, 1'b0, "mhartid_ro"};
    vecs[8]  = '{12'hF11, 64'h1234, 64'h0, 1'b0, "mvendorid_ro"};
    vecs[9]  = '{12'h342, 64'h8000_0000_0000_000B, 64'h8000_0000_0000_000B, 1'b0, "mcause"};
    vecs[10] = '{12'h343, 64'hCAFE, 64'hCAFE, 1'b0, "mtval"};
    vecs[11] = '{12'h304, 64'h888, 64'h888, 1'b0, "mie"};
    vecs[12] = '{12'h7C0, 64'h55, 64'h0, 1'b1, "unimpl_7c0"};
    vecs[13] = '{12'hF12, 64'h1, 64'h0, 1'b0, "marchid_ro"};
    vecs[14] = '{12'hF13, 64'h1, 64'h0, 1'b0, "mimpid_ro"};

    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0; bus.wvalid = 1'b0;
    retire_i = 1'b0; trap_valid_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    rd(CSR_MCYCLE, 64'd0, 1'b0, "rst_mcycle");
    rd(CSR_MSTATUS, 64'h1800, 1'b0, "rst_mstatus");
    rd(CSR_MTVEC, 64'h0, 1'b0, "rst_mtvec");
    rd(CSR_MHARTID, HART, 1'b0, "rst_mhartid");
    rd(CSR_MINSTRET, 64'd0, 1'b0, "rst_minstret");
    rd(12'h7C0, 64'h0, 1'b1, "rst_unimpl");
    chk("rst_mtvec_o", mtvec_o, 64'h0);
    chk("rst_mepc_o", mepc_o, 64'h0);
    chk("rst_mie_o", {63'd0, mie_o}, 64'd0);
    step();
    rd(CSR_MCYCLE, 64'd1, 1'b0, "mcycle_first_edge");

    // Same-cycle read returns the pre-write value
    bus.wvalid = 1'b1; bus.waddr = CSR_MSCRATCH; bus.wdata = 64'hDEAD_BEEF;
    rd(CSR_MSCRATCH, 64'h0, 1'b0, "mscratch_same_cycle");
    step();
    bus.wvalid = 1'b0;
    rd(CSR_MSCRATCH, 64'hDEAD_BEEF, 1'b0, "mscratch_next_cycle");

    foreach (vecs[i]) begin
      wr(vecs[i].a, vecs[i].wd);
      rd(vecs[i].a, vecs[i].exp, vecs[i].ill, vecs[i].nm);
    end
    chk("mtvec_o", mtvec_o, 64'h8000_0001);

    // Counters
    wr(CSR_MCYCLE, 64'd0);
    rd(CSR_MCYCLE, 64'd0, 1'b0, "mcycle_load0");
    repeat (10) step();
    rd(CSR_MCYCLE, 64'd10, 1'b0, "mcycle_10");
    wr(CSR_MINSTRET, 64'd0);
    repeat (3) begin
      retire_i = 1'b1; step();
      retire_i = 1'b0; step();
    end
    rd(CSR_MINSTRET, 64'd3, 1'b0, "minstret_3");
    retire_i = 1'b1;
    wr(CSR_MINSTRET, 64'd50);
    retire_i = 1'b0;
    rd(CSR_MINSTRET, 64'd50, 1'b0, "minstret_write_wins");
    wr(CSR_MCYCLE, 64'd100);
    rd(CSR_MCYCLE, 64'd100, 1'b0, "mcycle_100");
    step();
    rd(CSR_MCYCLE, 64'd101, 1'b0, "mcycle_101");
    wr(CSR_MCYCLE, '1);
    rd(CSR_MCYCLE, '1, 1'b0, "mcycle_max");
    step();
    rd(CSR_MCYCLE, 64'd0, 1'b0, "mcycle_wrap");

    // Trap entry beats a same-cycle mepc write
    wr(CSR_MSTATUS, 64'h8);
    rd(CSR_MSTATUS, 64'h1808, 1'b0, "mstatus_mie1");
    chk("mie_o_set", {63'd0, mie_o}, 64'd1);
    trap_valid_i = 1'b1; trap_cause_i = 64'd2; trap_pc_i = 64'h1235; trap_tval_i = 64'h13;
    wr(CSR_MEPC, 64'hAAA0);
    trap_valid_i = 1'b0;
    rd(CSR_MEPC, 64'h1234, 1'b0, "trap_mepc");
    rd(CSR_MCAUSE, 64'd2, 1'b0, "trap_mcause");
    rd(CSR_MTVAL, 64'h13, 1'b0, "trap_mtval");
    rd(CSR_MSTATUS, 64'h1880, 1'b0, "trap_mstatus");
    chk("trap_mepc_o", mepc_o, 64'h1234);
    chk("trap_mie_o", {63'd0, mie_o}, 64'd0);

    // mret
    mret_i = 1'b1; step(); mret_i = 1'b0;
    rd(CSR_MSTATUS, 64'h1888, 1'b0, "mret_mstatus");
    chk("mret_mie_o", {63'd0, mie_o}, 64'd1);

    // Trap and mret together: trap only; unrelated CSR write still lands
    trap_valid_i = 1'b1; mret_i = 1'b1;
    trap_cause_i = 64'd7; trap_pc_i = 64'h2000; trap_tval_i = 64'h0;
    wr(CSR_MSCRATCH, 64'd77);
    trap_valid_i = 1'b0; mret_i = 1'b0;
    rd(CSR_MSTATUS, 64'h1880, 1'b0, "trap_mret_mstatus");
    rd(CSR_MCAUSE, 64'd7, 1'b0, "trap_mret_mcause");
    rd(CSR_MEPC, 64'h2000, 1'b0, "trap_mret_mepc");
    rd(CSR_MSCRATCH, 64'd77, 1'b0, "trap_other_write");

    // Async reset mid-count
    wr(CSR_MCYCLE, 64'd500);
    step();
    #5 rstn = 1'b0;
    rd(CSR_MCYCLE, 64'd0, 1'b0, "async_rst_mcycle");
    rd(CSR_MSTATUS, 64'h1800, 1'b0, "async_rst_mstatus");
    rd(CSR_MSCRATCH, 64'h0, 1'b0, "async_rst_mscratch");
    #3 rstn = 1'b1;
    @(negedge clk);
    rd(CSR_MCYCLE, 64'd1, 1'b0, "post_rst_mcycle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
